// File: rtl/uart_alu_sequencer.sv
// Sequencer between the UART receiver/transmitter and the combinational ALU:
// collects A, B and opcode bytes, executes one operation and transmits the result.
module uart_alu_sequencer #(
  parameter int DATA_WIDTH = 8,
  parameter int OP_WIDTH   = 6,
  parameter int TIMEOUT    = 1000000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] i_rx_data,
  input  logic                  i_rx_done,
  input  logic [DATA_WIDTH-1:0] i_alu_result,
  input  logic                  i_tx_done,
  output logic [DATA_WIDTH-1:0] o_alu_a,
  output logic [DATA_WIDTH-1:0] o_alu_b,
  output logic [OP_WIDTH-1:0]   o_alu_op,
  output logic                  o_tx_start,
  output logic [DATA_WIDTH-1:0] o_tx_data,
  output logic                  o_busy,
  output logic                  o_error
);

  localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
  localparam int N_OPS = 8;
  localparam logic [OP_WIDTH-1:0] VALID_OPS [N_OPS] = '{
    OP_WIDTH'(6'b100000), OP_WIDTH'(6'b100010), OP_WIDTH'(6'b100100),
    OP_WIDTH'(6'b100101), OP_WIDTH'(6'b100110), OP_WIDTH'(6'b100111),
    OP_WIDTH'(6'b000011), OP_WIDTH'(6'b000010)
  };

  typedef enum logic [2:0] {WAIT_A, WAIT_B, WAIT_OP, EXEC, WAIT_TX} state_t;

  state_t                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] alu_a_q, alu_a_d;
  logic [DATA_WIDTH-1:0] alu_b_q, alu_b_d;
  logic [OP_WIDTH-1:0]   alu_op_q, alu_op_d;
  logic                  tx_start_q, tx_start_d;
  logic [DATA_WIDTH-1:0] tx_data_q, tx_data_d;
  logic                  busy_q, busy_d;
  logic                  error_q, error_d;

  logic [N_OPS-1:0]      op_hit;
  logic                  op_valid;
  logic                  expired;

  // Opcode byte is accepted only if its low bits match a supported
  // operation and every bit above the opcode field is zero.
  for (genvar gi = 0; gi < N_OPS; gi++) begin : g_op_match
    assign op_hit[gi] = (i_rx_data[OP_WIDTH-1:0] == VALID_OPS[gi]);
  end
  assign op_valid = (op_hit != '0) && ((i_rx_data >> OP_WIDTH) == '0);
  assign expired  = (cnt_q == CNT_LAST);

  always_comb begin
    state_d    = state_q;
    alu_a_d    = alu_a_q;
    alu_b_d    = alu_b_q;
    alu_op_d   = alu_op_q;
    tx_data_d  = tx_data_q;
    error_d    = error_q;
    tx_start_d = 1'b0;
    case (state_q)
      WAIT_A: begin
        if (i_rx_done) begin
          alu_a_d = i_rx_data;
          error_d = 1'b0;
          state_d = WAIT_B;
        end
      end
      WAIT_B: begin
        if (i_rx_done) begin
          alu_b_d = i_rx_data;
          state_d = WAIT_OP;
        end else if (expired) begin
          error_d = 1'b1;
          state_d = WAIT_A;
        end
      end
      WAIT_OP: begin
        if (i_rx_done) begin
          if (op_valid) begin
            alu_op_d = i_rx_data[OP_WIDTH-1:0];
            state_d  = EXEC;
          end else begin
            error_d = 1'b1;
            state_d = WAIT_A;
          end
        end else if (expired) begin
          error_d = 1'b1;
          state_d = WAIT_A;
        end
      end
      EXEC: begin
        tx_data_d  = i_alu_result;
        tx_start_d = 1'b1;
        state_d    = WAIT_TX;
      end
      WAIT_TX: begin
        // Received bytes are dropped here; only the transmitter matters.
        if (i_tx_done) begin
          state_d = WAIT_A;
        end else if (expired) begin
          error_d = 1'b1;
          state_d = WAIT_A;
        end
      end
      default: state_d = WAIT_A;
    endcase

    if (state_d != state_q) begin
      cnt_d = '0;
    end else if (state_q inside {WAIT_B, WAIT_OP, WAIT_TX}) begin
      cnt_d = cnt_q + 1'b1;
    end else begin
      cnt_d = '0;
    end
    busy_d = (state_d != WAIT_A);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= WAIT_A;
      cnt_q      <= '0;
      alu_a_q    <= '0;
      alu_b_q    <= '0;
      alu_op_q   <= '0;
      tx_start_q <= 1'b0;
      tx_data_q  <= '0;
      busy_q     <= 1'b0;
      error_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      alu_a_q    <= alu_a_d;
      alu_b_q    <= alu_b_d;
      alu_op_q   <= alu_op_d;
      tx_start_q <= tx_start_d;
      tx_data_q  <= tx_data_d;
      busy_q     <= busy_d;
      error_q    <= error_d;
    end
  end

  assign o_alu_a    = alu_a_q;
  assign o_alu_b    = alu_b_q;
  assign o_alu_op   = alu_op_q;
  assign o_tx_start = tx_start_q;
  assign o_tx_data  = tx_data_q;
  assign o_busy     = busy_q;
  assign o_error    = error_q;

endmodule

// File: doc/uart_alu_sequencer.md
Name: uart_alu_sequencer

Overview:
- Control FSM between the UART receiver/transmitter and the combinational ALU in the UART-ALU top level.
- Collects three received bytes in order (operand A, operand B, opcode), drives them to the ALU, captures the result and launches one UART transmission of it.
- Recovers from stalled frames with an inter-byte timeout and rejects unsupported opcodes.

Parameters:
- DATA_WIDTH, 8, operand/result/UART byte width
- OP_WIDTH, 6, ALU opcode width (low OP_WIDTH bits of the opcode byte)
- TIMEOUT, 1000000, clk cycles allowed in any waiting state after the first byte before abort (20 ms at 50 MHz)

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset
- i_rx_data  in  DATA_WIDTH  byte from UART receiver, valid when i_rx_done=1
- i_rx_done  in  1  one-cycle pulse: new byte received
- i_alu_result  in  DATA_WIDTH  combinational ALU output of o_alu_a/o_alu_b/o_alu_op
- i_tx_done  in  1  one-cycle pulse: UART transmitter finished the byte
- o_alu_a  out  DATA_WIDTH  registered operand A
- o_alu_b  out  DATA_WIDTH  registered operand B
- o_alu_op  out  OP_WIDTH  registered opcode
- o_tx_start  out  1  one-cycle pulse: start transmitting o_tx_data
- o_tx_data  out  DATA_WIDTH  registered result byte to transmit
- o_busy  out  1  high in every state except WAIT_A
- o_error  out  1  sticky error flag

Behaviour:
- Reset (reset=0, asynchronous): state WAIT_A; all outputs 0; timeout counter 0.
- States: WAIT_A, WAIT_B, WAIT_OP, EXEC, WAIT_TX.
- WAIT_A, on i_rx_done:
  - o_alu_a <= i_rx_data; o_error <= 0; go to WAIT_B.
  - No timeout applies in WAIT_A.
- WAIT_B, on i_rx_done: o_alu_b <= i_rx_data; go to WAIT_OP.
- WAIT_OP, on i_rx_done:
  - Valid opcode (bits [7:6]=0 and low 6 bits in {ADD 100000, SUB 100010, AND 100100, OR 100101, XOR 100110, NOR 100111, SRA 000011, SRL 000010}): o_alu_op <= low 6 bits; go to EXEC.
  - Otherwise: o_error <= 1; o_alu_op unchanged; go to WAIT_A; no transmission.
- EXEC (exactly one cycle): o_tx_data <= i_alu_result; o_tx_start <= 1; go to WAIT_TX.
- WAIT_TX:
  - o_tx_start back to 0 after one cycle.
  - On i_tx_done: go to WAIT_A.
  - i_rx_done pulses here are ignored; the byte is dropped.
- Latency: opcode i_rx_done sampled at edge N -> o_tx_start high after edge N+1, low after edge N+2.
- Timeout:
  - Counter clears on every state change.
  - Counter increments each cycle in WAIT_B, WAIT_OP and WAIT_TX.
  - When it reaches TIMEOUT-1 without the awaited event: o_error <= 1; go to WAIT_A; counter 0.
  - If i_rx_done (or i_tx_done in WAIT_TX) arrives on the expiry cycle, the event wins and no error is raised.
- Outputs are held between updates; o_alu_a/b/op stay stable during EXEC and WAIT_TX.
- o_error stays set until the next byte is accepted in WAIT_A, or until reset.
- Reset asserted mid-sequence aborts immediately; any o_tx_start in progress drops to 0.

Test Plan:
- A=0x0A, B=0x17, op=0x24 (AND), gaps of 3 bit-times -> o_alu_a=0x0A, o_alu_b=0x17, o_alu_op=6'b100100; one o_tx_start pulse 2 edges after the opcode; o_tx_data=0x02; o_error=0; o_busy falls after i_tx_done.
- A=0x0A, B=0x17, op=0x20 (ADD), ALU model returns 0x21 -> o_tx_data=0x21; back-to-back second frame A=0xFF, B=0x01, op=0x22 (SUB) -> o_tx_data=0xFE.
- A=0x05, B=0x03, op=0x3F -> o_error=1, no o_tx_start, state WAIT_A; next frame 0x01,0x02,0x25 (OR) clears o_error on first byte and sends 0x03.
- TIMEOUT=100 override; A=0x11 then silence -> o_error=1 exactly 100 cycles after entering WAIT_B; next byte 0x22 is latched into o_alu_a, not o_alu_b.
- i_rx_done pulse (0x55) during WAIT_TX -> ignored, o_alu_a unchanged; after i_tx_done the next byte becomes A.
- Assert reset for 2 cycles after byte B -> all outputs 0 at once, o_busy=0; full frame 0x0A,0x17,0x24 afterwards yields 0x02.
